mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 The ports SHALL be (name, direction, width, meaning):
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- opcode, in, 6, IR[31:26].
- funct, in, 6, IR[5:0].
- zero, in, 1, ALU zero flag.
REQ-003 The output ports SHALL be:
- pc_en, out, 1, PC load enable.
- iord, out, 1, memory address select (0 = PC, 1 = ALUOut).
- mem_read, out, 1, memory read strobe.
- mem_write, out, 1, memory write strobe.
- ir_write, out, 1, instruction register load.
- reg_dst, out, 1, write register select (0 = rt, 1 = rd).
- mem_to_reg, out, 1, write-back source (0 = ALUOut, 1 = MDR).
- reg_write, out, 1, register-file write enable.
REQ-004 The ALU-steering output ports SHALL be:
- alu_src_a, out, 1, ALU A select (0 = PC, 1 = A register).
- alu_src_b, out, 2, ALU B select (00 = B register, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2).
- pc_src, out, 2, PC source (00 = ALU result, 01 = ALUOut, 10 = jump target).
- alu_ctrl, out, 3, ALU operation code.
- state, out, 4, current FSM state (debug).
REQ-005 The alu_ctrl codes SHALL be AND=000, OR=001, ADD=010, OFF=011, SUB=110, SLT=111.

Function
REQ-006 The block SHALL be a Moore FSM with the following state encodings:
- FETCH=0, DECODE=1, MEM_ADR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5.
- EXEC=6, ALU_WB=7, BRANCH=8, JUMP=9, IMM_EXEC=10, IMM_WB=11.
REQ-007 pc_en in BRANCH SHALL be the only Mealy output, equal to zero combinationally in the same cycle.
REQ-008 Every output not listed for a state SHALL be 0, and alu_ctrl SHALL be OFF in any state that does not list it.
REQ-009 FETCH SHALL drive mem_read=1, iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_ctrl=ADD, pc_src=00, pc_en=1, and go to DECODE.
REQ-010 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_ctrl=ADD, and go to the next state by opcode:
- 100011 (lw) or 101011 (sw) -> MEM_ADR.
- 000000 (R-type) -> EXEC.
- 000100 (beq) -> BRANCH.
- 000010 (j) -> JUMP.
- any other opcode -> FETCH.
REQ-011 MEM_ADR SHALL drive alu_src_a=1, alu_src_b=10, alu_ctrl=ADD, and go to MEM_RD for lw or MEM_WR for sw.
REQ-012 MEM_RD SHALL drive mem_read=1, iord=1 and go to MEM_WB.
REQ-013 MEM_WB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=1 and go to FETCH.
REQ-014 MEM_WR SHALL drive mem_write=1, iord=1 and go to FETCH.
REQ-015 EXEC SHALL drive alu_src_a=1, alu_src_b=00, and set alu_ctrl from funct:
- 100000 -> ADD; 100010 -> SUB; 100100 -> AND; 100101 -> OR; 101010 -> SLT.
- any other funct -> OFF.
- next state ALU_WB.
REQ-016 ALU_WB SHALL drive reg_dst=1, mem_to_reg=0, and reg_write=1 only if funct is one of the five legal codes; next state FETCH.
REQ-017 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_ctrl=SUB, pc_src=01, pc_en=zero, and go to FETCH.
REQ-018 JUMP SHALL drive pc_src=10, pc_en=1 and go to FETCH.
REQ-019 Instruction latencies SHALL be: lw 5 cycles, sw 4, R-type 4, beq 3, j 3, and illegal opcode 2, each counted from FETCH to the next FETCH inclusive of FETCH.
REQ-020 opcode and funct SHALL be sampled only in DECODE, EXEC, ALU_WB, MEM_ADR and IMM_EXEC, and SHALL be ignored in all other states.

Reset
REQ-021 While rst_n=0 the state SHALL be FETCH and all outputs SHALL be forced to 0, with alu_ctrl=OFF, independent of clk.
REQ-022 Assertion of rst_n mid-instruction SHALL abort the instruction immediately, with no further strobes.
REQ-023 After rst_n deasserts, FETCH outputs SHALL appear combinationally, and the first transition SHALL occur at the next rising clk edge.

Configuration
REQ-024 With IMM_ARITH_EN defined, DECODE SHALL route opcode 001000 (addi) and 001010 (slti) to IMM_EXEC.
REQ-025 With IMM_ARITH_EN defined, IMM_EXEC SHALL drive alu_src_a=1, alu_src_b=10, alu_ctrl=ADD for addi or SLT for slti, and go to IMM_WB.
REQ-026 With IMM_ARITH_EN defined, IMM_WB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0 and go to FETCH, giving 4-cycle latency.
REQ-027 Without IMM_ARITH_EN, states 10 and 11 SHALL be unreachable and opcodes 001000 and 001010 SHALL be treated as illegal (DECODE -> FETCH).

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- Reset then lw (opcode=100011): state sequence 0,1,2,3,4,0; mem_read=1 in states 0 and 3; reg_write=1 only in state 4 with mem_to_reg=1.
- R-type sub (funct=100010): alu_ctrl=110 in EXEC; reg_write=1, reg_dst=1 in ALU_WB; R-type slt (funct=101010): alu_ctrl=111 in EXEC.
- beq with zero=1 gives pc_en=1, pc_src=01 in BRANCH; with zero=0, pc_en=0; toggling zero mid-cycle in BRANCH makes pc_en follow it combinationally.
- Illegal opcode 111111: sequence 0,1,0 with no mem_write or reg_write; R-type funct 000000 gives alu_ctrl=011 and reg_write=0 in ALU_WB.
- sw with rst_n pulsed low in MEM_ADR: outputs go 0 asynchronously, mem_write is never asserted, and state=FETCH.
- addi (opcode=001000) with IMM_ARITH_EN defined: sequence 0,1,10,11,0 with alu_ctrl=010; without the macro: sequence 0,1,0.

Source files
------------

// File: rtl/mc_controller.sv
// Purpose : multi-cycle MIPS-subset main controller; Moore FSM steering datapath muxes, strobes and ALU op.
// Latency : per instruction from FETCH to next FETCH: lw 5, sw 4, R-type 4, beq 3, j 3, addi/slti 4, illegal 2.
// Backpres: none; advances one state per clk, no stall input. pc_en in BRANCH follows zero combinationally.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   opcode, funct, zero instruction fields IR[31:26] / IR[5:0] and ALU zero flag
//   pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write  datapath strobes/selects
//   alu_src_a, alu_src_b, pc_src, alu_ctrl   ALU / PC steering
//   state                current FSM state (debug)
//
// Build option: define IMM_ARITH_EN to add addi/slti via IMM_EXEC/IMM_WB (states 10/11).
module mc_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_ctrl,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADR  = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_ALU_WB   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_IMM_EXEC = 4'd10,
        S_IMM_WB   = 4'd11
    } state_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_OFF = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    state_t state_q;
    state_t state_d;
    logic   funct_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    always_comb begin
        state_d    = state_q;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_ctrl   = ALU_OFF;
        funct_ok   = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                     (funct == FN_OR)  || (funct == FN_SLT);

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                alu_src_b = 2'b01;
                alu_ctrl  = ALU_ADD;
                pc_en     = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                // Speculative branch target: PC+4 + (imm << 2) into ALUOut.
                alu_src_b = 2'b11;
                alu_ctrl  = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef IMM_ARITH_EN
                    OP_ADDI, OP_SLTI: state_d = S_IMM_EXEC;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                // An opcode that is neither lw nor sw here means IR changed; drop back without touching memory.
                if (opcode == OP_LW) begin
                    state_d = S_MEM_RD;
                end else if (opcode == OP_SW) begin
                    state_d = S_MEM_WR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_OFF;
                endcase
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_dst   = 1'b1;
                reg_write = funct_ok;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_src    = 2'b01;
                // Only Mealy output: take the branch in the same cycle the compare resolves.
                pc_en     = zero;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_src  = 2'b10;
                pc_en   = 1'b1;
                state_d = S_FETCH;
            end
`ifdef IMM_ARITH_EN
            S_IMM_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
                state_d   = S_IMM_WB;
            end
            S_IMM_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset masks every strobe immediately, without waiting for a clock edge.
        if (!rst_n) begin
            state_d    = S_FETCH;
            pc_en      = 1'b0;
            iord       = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            pc_src     = 2'b00;
            alu_ctrl   = ALU_OFF;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_ctrl;
    logic [3:0] state;

    mc_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .pc_en      (pc_en),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .alu_ctrl   (alu_ctrl),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector layout:
    // [19:16] state, [15] pc_en, [14] iord, [13] mem_read, [12] mem_write, [11] ir_write,
    // [10] reg_dst, [9] mem_to_reg, [8] reg_write, [7] alu_src_a, [6:5] alu_src_b, [4:3] pc_src, [2:0] alu_ctrl
    logic [19:0] dut_v;
    assign dut_v = {state, pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                    alu_src_a, alu_src_b, pc_src, alu_ctrl};

    //                                       st     strobes        a     b      pc     alu
    localparam logic [19:0] V_RESET     = {4'd0,  8'b0000_0000, 1'b0, 2'b00, 2'b00, 3'b011};
    localparam logic [19:0] V_FETCH     = {4'd0,  8'b1010_1000, 1'b0, 2'b01, 2'b00, 3'b010};
    localparam logic [19:0] V_DECODE    = {4'd1,  8'b0000_0000, 1'b0, 2'b11, 2'b00, 3'b010};
    localparam logic [19:0] V_MEM_ADR   = {4'd2,  8'b0000_0000, 1'b1, 2'b10, 2'b00, 3'b010};
    localparam logic [19:0] V_MEM_RD    = {4'd3,  8'b0110_0000, 1'b0, 2'b00, 2'b00, 3'b011};
    localparam logic [19:0] V_MEM_WB    = {4'd4,  8'b0000_0011, 1'b0, 2'b00, 2'b00, 3'b011};
    localparam logic [19:0] V_EXEC_SUB  = {4'd6,  8'b0000_0000, 1'b1, 2'b00, 2'b00, 3'b110};
    localparam logic [19:0] V_EXEC_SLT  = {4'd6,  8'b0000_0000, 1'b1, 2'b00, 2'b00, 3'b111};
    localparam logic [19:0] V_EXEC_BAD  = {4'd6,  8'b0000_0000, 1'b1, 2'b00, 2'b00, 3'b011};
    localparam logic [19:0] V_ALUWB_OK  = {4'd7,  8'b0000_0101, 1'b0, 2'b00, 2'b00, 3'b011};
    localparam logic [19:0] V_ALUWB_BAD = {4'd7,  8'b0000_0100, 1'b0, 2'b00, 2'b00, 3'b011};
    localparam logic [19:0] V_BR_Z1     = {4'd8,  8'b1000_0000, 1'b1, 2'b00, 2'b01, 3'b110};
    localparam logic [19:0] V_BR_Z0     = {4'd8,  8'b0000_0000, 1'b1, 2'b00, 2'b01, 3'b110};
    localparam logic [19:0] V_JUMP      = {4'd9,  8'b1000_0000, 1'b0, 2'b00, 2'b10, 3'b011};
`ifdef IMM_ARITH_EN
    localparam logic [19:0] V_IMM_ADDI  = {4'd10, 8'b0000_0000, 1'b1, 2'b10, 2'b00, 3'b010};
    localparam logic [19:0] V_IMM_WB    = {4'd11, 8'b0000_0001, 1'b0, 2'b00, 2'b00, 3'b011};
`endif

    typedef struct {
        string       name;
        logic [19:0] v;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;
    int   n_vec = 0;
    int   n_bad = 0;
    logic saw_mem_write;

    // Monitor: whenever the stimulus says outputs are settled, compare against queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (dut_v !== e.v) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h (state %0d)", e.name, dut_v, e.v, state);
                end
            end
        end
    end

    // Sticky detector for any write strobe during the aborted sw.
    always @(posedge clk or posedge mem_write) begin
        if (mem_write) saw_mem_write = 1'b1;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [19:0] v);
        exp_t e;
        e.name = nm;
        e.v    = v;
        exp_q.push_back(e);
        ->sample_ev;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_tick(input string nm, input logic [19:0] v);
        chk(nm, v);
        tick();
    endtask

    initial begin
        rst_n  = 1'b0;
        opcode = 6'b100011;
        funct  = 6'b000000;
        zero   = 1'b0;
        saw_mem_write = 1'b0;
        #3;
        chk("reset_idle", V_RESET);
        @(posedge clk);
        #1;
        chk("reset_after_edge", V_RESET);
        #1;
        rst_n = 1'b1;
        #1;
        // lw: 0,1,2,3,4,0
        chk("lw_fetch_comb", V_FETCH);
        tick();
        chk_tick("lw_decode", V_DECODE);
        chk_tick("lw_mem_adr", V_MEM_ADR);
        opcode = 6'b111111;            // ignored outside sampling states
        chk_tick("lw_mem_rd", V_MEM_RD);
        chk_tick("lw_mem_wb", V_MEM_WB);

        // R-type sub
        opcode = 6'b000000;
        funct  = 6'b100010;
        chk_tick("sub_fetch", V_FETCH);
        chk_tick("sub_decode", V_DECODE);
        chk_tick("sub_exec", V_EXEC_SUB);
        chk_tick("sub_alu_wb", V_ALUWB_OK);

        // R-type slt
        funct = 6'b101010;
        chk_tick("slt_fetch", V_FETCH);
        chk_tick("slt_decode", V_DECODE);
        chk_tick("slt_exec", V_EXEC_SLT);
        chk_tick("slt_alu_wb", V_ALUWB_OK);

        // R-type illegal funct
        funct = 6'b000000;
        chk_tick("rbad_fetch", V_FETCH);
        chk_tick("rbad_decode", V_DECODE);
        chk_tick("rbad_exec", V_EXEC_BAD);
        chk_tick("rbad_alu_wb", V_ALUWB_BAD);

        // beq taken, then zero toggled inside BRANCH
        opcode = 6'b000100;
        zero   = 1'b1;
        chk_tick("beq1_fetch", V_FETCH);
        chk_tick("beq1_decode", V_DECODE);
        chk("beq1_branch_z1", V_BR_Z1);
        zero = 1'b0;
        #1;
        chk("beq1_branch_z_fall", V_BR_Z0);
        zero = 1'b1;
        #1;
        chk("beq1_branch_z_rise", V_BR_Z1);
        tick();

        // beq not taken
        zero = 1'b0;
        chk_tick("beq0_fetch", V_FETCH);
        chk_tick("beq0_decode", V_DECODE);
        chk_tick("beq0_branch", V_BR_Z0);

        // j
        opcode = 6'b000010;
        chk_tick("j_fetch", V_FETCH);
        chk_tick("j_decode", V_DECODE);
        chk_tick("j_jump", V_JUMP);

        // illegal opcode 111111: 0,1,0
        opcode = 6'b111111;
        chk_tick("ill_fetch", V_FETCH);
        chk_tick("ill_decode", V_DECODE);

        // sw aborted by reset in MEM_ADR
        opcode = 6'b101011;
        chk_tick("sw_fetch", V_FETCH);
        chk_tick("sw_decode", V_DECODE);
        saw_mem_write = 1'b0;
        chk("sw_mem_adr", V_MEM_ADR);
        #1;
        rst_n = 1'b0;
        #1;
        chk("sw_async_reset", V_RESET);
        tick();
        chk("sw_reset_held", V_RESET);
        tick();
        #1;
        rst_n = 1'b1;
        #1;
        chk("sw_release_fetch", V_FETCH);
        n_vec++;
        if (saw_mem_write !== 1'b0) begin
            n_bad++;
            $display("FAIL sw_no_mem_write: got %b expected 0", saw_mem_write);
        end
        tick();
        chk("sw_restart_decode", V_DECODE);
        tick();
        chk_tick("sw_restart_mem_adr", V_MEM_ADR);
        opcode = 6'b000000;
        tick();                         // MEM_WR -> FETCH

        // addi
        opcode = 6'b001000;
        chk_tick("addi_fetch", V_FETCH);
        chk_tick("addi_decode", V_DECODE);
`ifdef IMM_ARITH_EN
        chk_tick("addi_imm_exec", V_IMM_ADDI);
        chk_tick("addi_imm_wb", V_IMM_WB);
`endif
        chk("addi_back_to_fetch", V_FETCH);

        #2;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
